parity_rr_scheduler: RTL

// - Shares one 8-bit XOR-reduction parity unit between NREQ requesters.
// - Requesters present bytes with a valid/ready handshake.
// - A round-robin arbiter grants one request at a time.
// - The block computes parity, optionally checks it against an expected bit,
//   and returns the result with the winner's ID over a valid/ready response port.
// - Keeps a saturating count of parity mismatches for status readout.

---
 rtl/parity_rr_scheduler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/parity_rr_scheduler.sv
// Round-robin scheduler sharing one byte-parity unit between NREQ requesters.
// One request is accepted per IDLE cycle; the registered result (parity,
// optional check error, winner id) is held in RESP until the consumer takes it.
// A saturating counter tallies responses delivered with the error flag set.
module parity_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int ERRW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_data,
    input  logic [NREQ-1:0]      req_chk,
    input  logic [NREQ-1:0]      req_exp,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic                 resp_par,
    output logic                 resp_err,
    output logic [ERRW-1:0]      err_count
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   resp_id_q;
    logic             resp_par_q;
    logic             resp_err_q;
    logic [ERRW-1:0]  err_cnt_q;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [7:0]       sel_byte;
    logic             sel_par;
    logic             accept;
    logic             resp_hs;

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] c);
        return (c == {ERRW{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Scan requesters starting at rr_ptr, wrapping modulo NREQ; first valid wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    assign sel_byte = req_data[8*int'(grant_idx) +: 8];
    assign sel_par  = byte_parity(sel_byte);
    assign accept   = (state_q == IDLE) && grant_found;
    assign resp_hs  = (state_q == RESP) && resp_ready;

    // State register; reset aborts any pending response.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: accept moves to RESP, consumer handshake returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = RESP;
            RESP:    if (resp_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: one-hot grant only while IDLE, response valid while in RESP.
    always_comb begin
        req_ready  = '0;
        resp_valid = 1'b0;
        if (state_q == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
        if (state_q == RESP) resp_valid = 1'b1;
    end

    // Capture the winner's result and advance the round-robin pointer past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            resp_id_q  <= '0;
            resp_par_q <= 1'b0;
            resp_err_q <= 1'b0;
        end else if (accept) begin
            resp_id_q  <= grant_idx;
            resp_par_q <= sel_par;
            resp_err_q <= req_chk[grant_idx] & (sel_par ^ req_exp[grant_idx]);
            rr_ptr_q   <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Count delivered error responses, sticking at the maximum value.
    always_ff @(posedge clk) begin
        if (rst)                    err_cnt_q <= '0;
        else if (resp_hs && resp_err_q) err_cnt_q <= sat_inc(err_cnt_q);
    end

    assign resp_id   = resp_id_q;
    assign resp_par  = resp_par_q;
    assign resp_err  = resp_err_q;
    assign err_count = err_cnt_q;

endmodule
